draw_sweep_ctrl: RTL and testbench
==================================

DRAW_SWEEP_CTRL -- requirements
Module: draw_sweep_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: width of each memory address, in words.
REQ-002 SHALL have parameter CNT_W, default 9: width of the pair-count and pair-index fields.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  sweep request; sampled only in IDLE.
REQ-006 SHALL have port base  input  ADDR_W  sweep base address; captured on an accepted start; bit 0 ignored.
REQ-007 SHALL have port pairs  input  CNT_W  number of address pairs to issue; captured on an accepted start.
REQ-008 SHALL have port abort  input  1  terminates a running sweep.
REQ-009 SHALL have port mem_ready  input  1  memory accepts the current pair this cycle.
REQ-010 SHALL have port busy  output  1  high in RUN and DONE.
REQ-011 SHALL have port valid  output  1  addr_a and addr_b carry a pair for the memory.
REQ-012 SHALL have port addr_a  output  ADDR_W  even address, port A.
REQ-013 SHALL have port addr_b  output  ADDR_W  odd address, port B.
REQ-014 SHALL have port idx  output  CNT_W  index of the current pair, 0-based.
REQ-015 SHALL have port done  output  1  one-cycle pulse on normal completion.

Function
REQ-016 SHALL implement a registered FSM with states IDLE, RUN and DONE.
REQ-017 IDLE with start=1 and pairs!=0 SHALL capture base[ADDR_W-1:1] and pairs, clear idx, and go to RUN.
REQ-018 IDLE with start=1 and pairs==0 SHALL go directly to DONE and SHALL issue no valid cycle.
REQ-019 start SHALL be ignored in RUN and DONE; no queuing.
REQ-020 valid SHALL be 1 exactly while the state is RUN, so the first pair appears the cycle after start is sampled.
REQ-021 addr_a SHALL equal {(base_hi + idx) mod 2^(ADDR_W-1), 1'b0}; addr_b SHALL equal the same value with bit 0 = 1.
REQ-022 Address arithmetic SHALL wrap modulo 2^(ADDR_W-1) pairs, with no error flag.
REQ-023 A pair SHALL be transferred when valid and mem_ready are both 1 in a cycle.
REQ-024 On a transfer, idx SHALL increment; addresses SHALL hold stable while mem_ready=0.
REQ-025 A transfer with idx == pairs-1 SHALL move the FSM to DONE; idx SHALL then hold its last value.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 Throughput SHALL be one pair per cycle when mem_ready is held high.
REQ-028 abort=1 in RUN SHALL return the FSM to IDLE next cycle, with no done pulse and no transfer counted, regardless of mem_ready.
REQ-029 abort in IDLE or DONE SHALL have no effect; DONE still pulses and returns to IDLE.
REQ-030 When abort and a last-pair transfer coincide, abort SHALL win.
REQ-031 Changes on base or pairs during RUN SHALL not affect the running sweep.

Reset
REQ-032 reset=1 SHALL immediately force, without waiting for clk: state IDLE; busy=0, valid=0, done=0; idx=0; addr_a=0; addr_b=1; captured base and count cleared.
REQ-033 reset asserted mid-sweep SHALL abandon the sweep with no done pulse.
REQ-034 After reset deasserts, the first start SHALL behave per REQ-017 and REQ-018.

Verification
REQ-035 Full sweep: base=6400, pairs=128, mem_ready=1 -> 128 valid cycles; addr_a 6400,6402..6654; addr_b 6401..6655; done pulses once on the cycle after the last pair; busy high for 129 cycles.
REQ-036 Stall: base=0, pairs=4, mem_ready low on every other cycle -> pairs (0,1),(2,3),(4,5),(6,7) each held while stalled; exactly 4 transfers; then done.
REQ-037 Wrap: ADDR_W=14, base=16380, pairs=4 -> addr_a 16380, 16382, 0, 2; addr_b 16381, 16383, 1, 3.
REQ-038 Zero count and restart: start with pairs=0 -> valid never high and done one cycle later; start pulsed during RUN -> ignored, so only one done.
REQ-039 Abort and coincidence: abort at idx=5 of 10 -> IDLE next cycle with no done; abort together with the last transfer -> no done.
REQ-040 Async reset: reset asserted between clock edges at idx=3 -> outputs reach reset values before the next edge; no done pulse afterwards.

Source files
------------

// File: rtl/draw_sweep_ctrl.sv
// Sweep controller that issues consecutive even/odd address pairs to a dual-port memory.
// A start captures the base and pair count; pairs advance on mem_ready and abort cancels silently.
module draw_sweep_ctrl #(
   parameter int ADDR_W = 14,
   parameter int CNT_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [CNT_W-1:0]  pairs,
   input  logic              abort,
   input  logic              mem_ready,
   output logic              busy,
   output logic              valid,
   output logic [ADDR_W-1:0] addr_a,
   output logic [ADDR_W-1:0] addr_b,
   output logic [CNT_W-1:0]  idx,
   output logic              done
);

   localparam int HI_W = ADDR_W - 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [HI_W-1:0]   base_hi_q, base_hi_d;
   logic [CNT_W-1:0]  pairs_q, pairs_d;
   logic [CNT_W-1:0]  idx_q, idx_d;
   logic              last_pair;
   logic [HI_W-1:0]   pair_addr;

   // Pair address wraps naturally in HI_W bits; idx is resized to the pair-address width.
   always_comb begin
      last_pair = (idx_q == (pairs_q - CNT_W'(1)));
      pair_addr = base_hi_q + HI_W'(idx_q);
   end

   always_comb begin
      state_d   = state_q;
      base_hi_d = base_hi_q;
      pairs_d   = pairs_q;
      idx_d     = idx_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               base_hi_d = base[ADDR_W-1:1];
               pairs_d   = pairs;
               idx_d     = '0;
               state_d   = (pairs == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            // Abort takes priority over any transfer, including the last one.
            if (abort) begin
               state_d = ST_IDLE;
            end else if (mem_ready) begin
               if (last_pair) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + CNT_W'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         base_hi_q <= '0;
         pairs_q   <= '0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         base_hi_q <= base_hi_d;
         pairs_q   <= pairs_d;
         idx_q     <= idx_d;
      end
   end

   always_comb begin
      busy   = (state_q != ST_IDLE);
      valid  = (state_q == ST_RUN);
      done   = (state_q == ST_DONE);
      addr_a = {pair_addr, 1'b0};
      addr_b = {pair_addr, 1'b1};
      idx    = idx_q;
   end

endmodule

// File: tb/tb_draw_sweep_ctrl.sv
// Directed bench for draw_sweep_ctrl: a per-cycle vector table plus hand-written
// sequences for the long sweep and asynchronous reset.
module tb_draw_sweep_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic [13:0] base;
   logic [8:0]  pairs;
   logic        abort;
   logic        mem_ready;
   logic        busy;
   logic        valid;
   logic [13:0] addr_a;
   logic [13:0] addr_b;
   logic [8:0]  idx;
   logic        done;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        start;
      logic [13:0] base;
      logic [8:0]  pairs;
      logic        abort;
      logic        rdy;
      logic        e_busy;
      logic        e_valid;
      logic        e_done;
      logic [13:0] e_a;
      logic [8:0]  e_idx;
      logic        chk_idx;
   } vec_t;

   vec_t vecs[64];
   int   nv = 0;

   draw_sweep_ctrl #(.ADDR_W(14), .CNT_W(9)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base      (base),
      .pairs     (pairs),
      .abort     (abort),
      .mem_ready (mem_ready),
      .busy      (busy),
      .valid     (valid),
      .addr_a    (addr_a),
      .addr_b    (addr_b),
      .idx       (idx),
      .done      (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [13:0] b, input logic [8:0] p,
                                input logic ab, input logic rdy);
      start     = st;
      base      = b;
      pairs     = p;
      abort     = ab;
      mem_ready = rdy;
   endtask

   task automatic addVec(input logic st, input logic [13:0] b, input logic [8:0] p,
                         input logic ab, input logic rdy,
                         input logic eb, input logic ev, input logic ed,
                         input logic [13:0] ea, input logic [8:0] ei, input logic ci);
      vecs[nv].start   = st;
      vecs[nv].base    = b;
      vecs[nv].pairs   = p;
      vecs[nv].abort   = ab;
      vecs[nv].rdy     = rdy;
      vecs[nv].e_busy  = eb;
      vecs[nv].e_valid = ev;
      vecs[nv].e_done  = ed;
      vecs[nv].e_a     = ea;
      vecs[nv].e_idx   = ei;
      vecs[nv].chk_idx = ci;
      nv++;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " busy"},   32'(busy),   0);
      checkOutput({tag, " valid"},  32'(valid),  0);
      checkOutput({tag, " done"},   32'(done),   0);
      checkOutput({tag, " idx"},    32'(idx),    0);
      checkOutput({tag, " addr_a"}, 32'(addr_a), 0);
      checkOutput({tag, " addr_b"}, 32'(addr_b), 1);
   endtask

   initial begin
      int nvalid;
      int nbusy;
      int ndone;
      int seen_busy;
      int found;

      // Each row: inputs driven this cycle, outputs expected during this cycle.
      // Wrap with odd base (bit 0 dropped), stall, base/pairs changed mid-run, start in DONE ignored.
      addVec(1, 16381, 4, 0, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  16380, 0, 1);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  16382, 1, 1);
      addVec(0, 0,     0, 0, 0,  1, 1, 0,  0,     2, 1);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  0,     2, 1);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  2,     3, 1);
      addVec(1, 500,   7, 0, 1,  1, 0, 1,  0,     3, 1);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      // Zero pair count goes straight to DONE.
      addVec(1, 100,   0, 0, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  1, 0, 1,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      // mem_ready low every other cycle.
      addVec(1, 0,     4, 0, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 0,  1, 1, 0,  0,     0, 1);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  0,     0, 1);
      addVec(0, 0,     0, 0, 0,  1, 1, 0,  2,     1, 1);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  2,     1, 1);
      addVec(0, 0,     0, 0, 0,  1, 1, 0,  4,     2, 1);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  4,     2, 1);
      addVec(0, 0,     0, 0, 0,  1, 1, 0,  6,     3, 1);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  6,     3, 1);
      addVec(0, 0,     0, 0, 1,  1, 0, 1,  0,     3, 1);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      // Abort at idx 5 of 10.
      addVec(1, 200,  10, 0, 1,  0, 0, 0,  0,     0, 0);
      for (int k = 0; k < 6; k++)
         addVec(0, 0, 0, (k == 5), 1,  1, 1, 0,  14'(200 + 2 * k), 9'(k), 1);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      // Abort coinciding with the last transfer.
      addVec(1, 20,    2, 0, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  20,    0, 1);
      addVec(0, 0,     0, 1, 1,  1, 1, 0,  22,    1, 1);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);
      // Abort in IDLE and in DONE has no effect.
      addVec(1, 40,    1, 1, 1,  0, 0, 0,  0,     0, 0);
      addVec(0, 0,     0, 0, 1,  1, 1, 0,  40,    0, 1);
      addVec(0, 0,     0, 1, 1,  1, 0, 1,  0,     0, 1);
      addVec(0, 0,     0, 0, 1,  0, 0, 0,  0,     0, 0);

      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0);
      #2;
      checkResetValues("reset");
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < nv; i++) begin
         applyStimulus(vecs[i].start, vecs[i].base, vecs[i].pairs, vecs[i].abort, vecs[i].rdy);
         @(negedge clk);
         checkOutput($sformatf("vec%0d busy", i),  32'(busy),  32'(vecs[i].e_busy));
         checkOutput($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].e_valid));
         checkOutput($sformatf("vec%0d done", i),  32'(done),  32'(vecs[i].e_done));
         if (vecs[i].e_valid) begin
            checkOutput($sformatf("vec%0d addr_a", i), 32'(addr_a), 32'(vecs[i].e_a));
            checkOutput($sformatf("vec%0d addr_b", i), 32'(addr_b), 32'(vecs[i].e_a | 14'd1));
         end
         if (vecs[i].chk_idx)
            checkOutput($sformatf("vec%0d idx", i), 32'(idx), 32'(vecs[i].e_idx));
         @(posedge clk);
         #1;
      end

      // Full 128-pair sweep at one pair per cycle.
      applyStimulus(1, 6400, 128, 0, 1);
      @(negedge clk);
      checkOutput("sweep idle before start", 32'(busy), 0);
      @(posedge clk);
      #1 applyStimulus(0, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("sweep first valid latency", 32'(valid), 1);
      nvalid    = 0;
      nbusy     = 0;
      ndone     = 0;
      seen_busy = 0;
      for (int c = 0; c < 300; c++) begin
         if (c != 0) @(negedge clk);
         if (valid) begin
            checkOutput($sformatf("sweep addr_a %0d", nvalid), 32'(addr_a), 32'(6400 + 2 * nvalid));
            checkOutput($sformatf("sweep addr_b %0d", nvalid), 32'(addr_b), 32'(6401 + 2 * nvalid));
            checkOutput($sformatf("sweep idx %0d", nvalid),    32'(idx),    32'(nvalid));
            nvalid++;
         end
         if (done) begin
            ndone++;
            checkOutput("sweep done after last pair", 32'(nvalid), 128);
         end
         if (busy) begin
            nbusy++;
            seen_busy = 1;
         end else if (seen_busy != 0) begin
            break;
         end
      end
      checkOutput("sweep valid count", 32'(nvalid), 128);
      checkOutput("sweep busy count",  32'(nbusy),  129);
      checkOutput("sweep done count",  32'(ndone),  1);
      checkOutput("sweep returned idle", 32'(busy), 0);

      // Asynchronous reset between clock edges at idx 3.
      @(posedge clk);
      #1 applyStimulus(1, 1000, 8, 0, 1);
      @(posedge clk);
      #1 applyStimulus(0, 0, 0, 0, 1);
      found = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (valid && idx == 9'd3) begin
            found = 1;
            break;
         end
      end
      checkOutput("async reset reached idx 3", 32'(found), 1);
      #2 reset = 1'b1;
      #1;
      checkResetValues("async reset");
      @(posedge clk);
      #1 reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      checkOutput("post reset no done", 32'(ndone), 0);
      checkOutput("post reset idle", 32'(busy), 0);

      // First start after reset, zero pairs.
      @(posedge clk);
      #1 applyStimulus(1, 300, 0, 0, 1);
      @(posedge clk);
      #1 applyStimulus(0, 0, 0, 0, 1);
      @(negedge clk);
      checkOutput("post reset zero done", 32'(done), 1);
      checkOutput("post reset zero valid", 32'(valid), 0);
      @(negedge clk);
      checkOutput("post reset zero idle", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
